// File: rtl/spi_reg_frame_decoder_pkg.sv
// Shared definitions for the SPI register frame decoder: FSM state encodings
// and command byte layout.
package spi_reg_frame_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA_LO = 2'd2,
        ST_DATA_HI = 2'd3
    } state_t;

    localparam int CMD_WR_BIT = 7;

endpackage

// File: rtl/spi_reg_frame_decoder_ssel_sync.sv
// Chip-select synchronizer: two sync flops plus an edge-detect flop, producing
// frame start/stop pulses and an active level aligned with those pulses.
module ssel_sync (
    input  logic clk,
    input  logic rst,
    input  logic ssel_n,
    output logic active,
    output logic start,
    output logic stop
);
    logic       s1, s2, prev, armed;
    logic [1:0] init;

    // armed stays low until the chain has settled and shown ssel_n inactive,
    // so a frame already in progress across reset is never picked up mid-way.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            prev  <= 1'b1;
            armed <= 1'b0;
            init  <= 2'b00;
        end else begin
            s1    <= ssel_n;
            s2    <= s1;
            prev  <= s2;
            init  <= {init[0], 1'b1};
            armed <= armed | (init[1] & s2);
        end
    end

    assign active = armed & ~prev;
    assign start  = armed & prev & ~s2;
    assign stop   = armed & ~prev & s2;

endmodule

// File: rtl/spi_reg_frame_decoder.sv
// Frame decoder: parses command byte + little-endian 16-bit words into register
// write strobes and read addresses, returning pre-write register contents.
module spi_reg_frame_decoder
    import spi_reg_frame_decoder_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ssel_n,
    input  logic              byte_done,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    input  logic [7:0]        status,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              frame_err
);
    logic ss_active, ss_start, ss_stop, byte_ok;

    ssel_sync u_ssel_sync (
        .clk    (clk),
        .rst    (rst),
        .ssel_n (ssel_n),
        .active (ss_active),
        .start  (ss_start),
        .stop   (ss_stop)
    );

    // The active level lags the pin like the edge pulses do, so a byte landing
    // with the stop pulse is still processed before the frame closes.
    assign byte_ok = byte_done & ss_active;

    state_t            state, state_nxt;
    logic              wr_flag, wr_flag_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        lo, lo_nxt;
    logic [15:0]       shadow, shadow_nxt;
    logic [7:0]        tx_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W-1:0] wr_addr_nxt;
    logic [15:0]       wr_data_nxt;
    logic              done_nxt, err_nxt;
    // [0] rd_addr updated, [1] rd_data valid -> capture, [2] shadow -> tx_byte
    logic [2:0]        vld_pipe, pipe_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_flag    <= 1'b0;
            rd_addr    <= '0;
            lo         <= '0;
            shadow     <= '0;
            tx_byte    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            state      <= state_nxt;
            wr_flag    <= wr_flag_nxt;
            rd_addr    <= addr_nxt;
            lo         <= lo_nxt;
            shadow     <= shadow_nxt;
            tx_byte    <= tx_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            vld_pipe   <= pipe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_flag_nxt = wr_flag;
        addr_nxt    = rd_addr;
        lo_nxt      = lo;
        shadow_nxt  = shadow;
        tx_nxt      = tx_byte;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        pipe_nxt    = {vld_pipe[1:0], 1'b0};

        if (vld_pipe[1]) shadow_nxt = rd_data;
        if (vld_pipe[2]) tx_nxt = shadow[7:0];

        case (state)
            ST_IDLE: begin
                tx_nxt = status;
                if (ss_start) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (byte_ok) begin
                    wr_flag_nxt = rx_byte[CMD_WR_BIT];
                    addr_nxt    = rx_byte[ADDR_W-1:0];
                    state_nxt   = ST_DATA_LO;
                    pipe_nxt[0] = 1'b1;
                end
            end
            ST_DATA_LO: begin
                if (byte_ok) begin
                    lo_nxt    = rx_byte;
                    tx_nxt    = shadow[15:8];
                    state_nxt = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (byte_ok) begin
                    wr_en_nxt = wr_flag;
                    if (wr_flag) begin
                        wr_addr_nxt = rd_addr;
                        wr_data_nxt = {rx_byte, lo};
                    end
                    addr_nxt    = rd_addr + ADDR_W'(1);
                    state_nxt   = ST_DATA_LO;
                    pipe_nxt[0] = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Judge the frame on the post-byte state so a coincident final byte counts.
        if (state != ST_IDLE && ss_stop) begin
            done_nxt  = (state_nxt != ST_DATA_HI);
            err_nxt   = (state_nxt == ST_DATA_HI);
            state_nxt = ST_IDLE;
            pipe_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_spi_reg_frame_decoder.sv
// Directed bench for spi_reg_frame_decoder with a small register file model.
module tb_spi_reg_frame_decoder;
    logic        clk = 1'b0;
    logic        rst, ssel_n, byte_done;
    logic [7:0]  rx_byte, tx_byte, status;
    logic [3:0]  rd_addr, wr_addr;
    logic [15:0] rd_data, wr_data;
    logic        wr_en, frame_done, frame_err;

    spi_reg_frame_decoder #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .ssel_n(ssel_n), .byte_done(byte_done),
        .rx_byte(rx_byte), .tx_byte(tx_byte), .status(status),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [15:0] regs [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_a = '0;
    logic [15:0] pre_d = '0;
    logic [3:0]  wa [$];
    logic [15:0] wd [$];
    int          n_done = 0, n_err_f = 0;
    int          n_chk = 0, n_err = 0;

    assign rd_data = regs[rd_addr];

    always @(negedge clk) begin
        if (pre_en) regs[pre_a] <= pre_d;
        else if (wr_en) regs[wr_addr] <= wr_data;
        if (!rst) begin
            if (wr_en) begin
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
            end
            if (frame_done) n_done++;
            if (frame_err) n_err_f++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [3:0] a, input logic [15:0] d);
        pre_a = a; pre_d = d; pre_en = 1'b1;
        tick(1);
        pre_en = 1'b0;
    endtask

    task automatic sel_low();
        ssel_n = 1'b0;
        tick(5);
    endtask

    task automatic sel_high();
        ssel_n = 1'b1;
        tick(6);
    endtask

    // Sample the byte the slave would shift out, then deliver the received byte.
    task automatic xfer(input logic [7:0] b, output logic [7:0] got);
        tick(8);
        got = tx_byte;
        rx_byte = b;
        byte_done = 1'b1;
        tick(1);
        byte_done = 1'b0;
    endtask

    initial begin
        logic [7:0] g;
        int wb, db, eb;
        rst = 1'b1; ssel_n = 1'b1; byte_done = 1'b0; rx_byte = '0; status = 8'hA5;
        tick(3);
        chk("rst_tx", tx_byte, 8'h00);
        chk("rst_rd_addr", rd_addr, 4'h0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 16'h0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        tick(4);
        chk("idle_tx", tx_byte, 8'hA5);

        // status byte + read burst
        status = 8'h5A;
        preset(4'h3, 16'hBEEF);
        preset(4'h4, 16'h1234);
        wb = wa.size(); db = n_done; eb = n_err_f;
        sel_low();
        xfer(8'h03, g); chk("rd_status", g, 8'h5A);
        xfer(8'h00, g); chk("rd_b0", g, 8'hEF);
        xfer(8'h00, g); chk("rd_b1", g, 8'hBE);
        xfer(8'h00, g); chk("rd_b2", g, 8'h34);
        xfer(8'h00, g); chk("rd_b3", g, 8'h12);
        sel_high();
        chk("rd_no_wr", wa.size() - wb, 0);
        chk("rd_done", n_done - db, 1);
        chk("rd_err", n_err_f - eb, 0);
        chk("rd_addr_end", rd_addr, 4'h5);

        // write burst wrapping F -> 0
        preset(4'hF, 16'hCAFE);
        preset(4'h0, 16'h9876);
        wb = wa.size(); db = n_done;
        sel_low();
        xfer(8'h8F, g); chk("wr_status", g, 8'h5A);
        xfer(8'h11, g); chk("wr_old0", g, 8'hFE);
        xfer(8'h22, g); chk("wr_old1", g, 8'hCA);
        xfer(8'h33, g); chk("wr_old2", g, 8'h76);
        xfer(8'h44, g); chk("wr_old3", g, 8'h98);
        sel_high();
        chk("wr_count", wa.size() - wb, 2);
        chk("wr0_addr", wa[wb], 4'hF);
        chk("wr0_data", wd[wb], 16'h2211);
        chk("wr1_addr", wa[wb+1], 4'h0);
        chk("wr1_data", wd[wb+1], 16'h4433);
        chk("wr_regF", regs[15], 16'h2211);
        chk("wr_reg0", regs[0], 16'h4433);
        chk("wr_done", n_done - db, 1);

        // abort mid-word
        wb = wa.size(); db = n_done; eb = n_err_f;
        sel_low();
        xfer(8'h82, g);
        xfer(8'hAA, g);
        sel_high();
        chk("ab_no_wr", wa.size() - wb, 0);
        chk("ab_err", n_err_f - eb, 1);
        chk("ab_done", n_done - db, 0);
        status = 8'h3C;
        tick(2);
        chk("ab_idle_tx", tx_byte, 8'h3C);

        // final DATA_HI byte coincides with recognised ssel_n rise
        db = n_done; eb = n_err_f;
        sel_low();
        xfer(8'h81, g);
        xfer(8'h55, g);
        tick(8);
        ssel_n = 1'b1;
        tick(2);
        rx_byte = 8'h66; byte_done = 1'b1;
        tick(1);
        byte_done = 1'b0;
        chk("co_wr_en", wr_en, 1'b1);
        chk("co_wr_addr", wr_addr, 4'h1);
        chk("co_wr_data", wr_data, 16'h6655);
        chk("co_done", frame_done, 1'b1);
        chk("co_err", frame_err, 1'b0);
        tick(1);
        chk("co_wr_en_1cyc", wr_en, 1'b0);
        chk("co_done_1cyc", frame_done, 1'b0);
        tick(6);
        chk("co_err_cnt", n_err_f - eb, 0);

        // reset mid-frame
        status = 8'hC3;
        sel_low();
        xfer(8'h82, g);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mr_tx", tx_byte, 8'h00);
        chk("mr_rd_addr", rd_addr, 4'h0);
        chk("mr_wr_en", wr_en, 1'b0);
        chk("mr_done", frame_done, 1'b0);
        chk("mr_err", frame_err, 1'b0);
        rst = 1'b0;
        wb = wa.size(); db = n_done; eb = n_err_f;
        xfer(8'h11, g); chk("mr_ign0", g, 8'hC3);
        xfer(8'h22, g); chk("mr_ign1", g, 8'hC3);
        xfer(8'h33, g);
        sel_high();
        chk("mr_no_wr", wa.size() - wb, 0);
        chk("mr_no_done", n_done - db, 0);
        chk("mr_no_err", n_err_f - eb, 0);
        preset(4'h1, 16'h0BAD);
        sel_low();
        xfer(8'h01, g); chk("mr_new_status", g, 8'hC3);
        xfer(8'h00, g); chk("mr_new_b0", g, 8'hAD);
        xfer(8'h00, g); chk("mr_new_b1", g, 8'h0B);
        sel_high();
        chk("mr_new_done", n_done - db, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
